obc_bitslice_sequencer: RTL and testbench

Bit-serial driver and shift-accumulator for the OBC/DA DFT bin ROM stages. It accepts one frame of 16 parallel two's-complement samples and presents them one bit-slice per cycle, LSB first, on the 16 slice lines and the MSB flag `m` of a bin ROM stage. It sign-extends and weights each returned 32-bit partial sum, accumulates them, and hands one result per frame downstream over a valid/ready handshake. One instance sits in front of each real or imaginary bin ROM stage.

---
 rtl/obc_bitslice_sequencer.sv | 122 ++++++++++++
 tb/tb_obc_bitslice_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/obc_bitslice_sequencer.sv
// Bit-serial slice driver and shift-accumulator for one OBC/DA bin ROM stage.
// Optional build macro OBC_ROUND_EN: round-half-up before the final arithmetic shift.
module obc_bitslice_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ROM_W     = 32,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*DATA_W-1:0]    samples,
  output logic [15:0]             slice,
  output logic                    m,
  input  logic [ROM_W-1:0]        rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] result
);

  localparam int NSMP = 16;
  localparam int BW   = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

`ifdef OBC_ROUND_EN
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND =
    (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             b_q, b_d, nb;
  logic [16*DATA_W-1:0]      frame_q, frame_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, res_q, res_d, sum;
  logic [15:0]               slice_q, slice_d;
  logic                      m_q, m_d;

  function automatic logic signed [ACC_W-1:0] sext_rom(input logic [ROM_W-1:0] r);
    return {{(ACC_W-ROM_W){r[ROM_W-1]}}, r};
  endfunction

  function automatic logic signed [ACC_W-1:0] scale_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = v;
`ifdef OBC_ROUND_EN
    t = t + RND;
`endif
    return t >>> OUT_SHIFT;
  endfunction

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    frame_d   = frame_q;
    acc_d     = acc_q;
    res_d     = res_q;
    slice_d   = '0;
    m_d       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    nb        = b_q + 1'b1;
    sum       = acc_q + (sext_rom(rom_data) <<< b_q);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          frame_d = samples;
          acc_d   = '0;
          b_d     = '0;
          state_d = SHIFT;
          // Slice 0 is loaded straight into the output register on the accept edge.
          for (int k = 0; k < NSMP; k++) slice_d[k] = samples[k*DATA_W];
        end
      end
      SHIFT: begin
        acc_d = sum;
        if (b_q == LAST) begin
          res_d   = scale_out(sum);
          b_d     = '0;
          state_d = DONE;
        end else begin
          b_d = nb;
          for (int k = 0; k < NSMP; k++) slice_d[k] = frame_q[k*DATA_W + int'(nb)];
          m_d = (nb == LAST);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      frame_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      slice_q <= '0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      frame_q <= frame_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      slice_q <= slice_d;
      m_q     <= m_d;
    end
  end

  assign slice  = slice_q;
  assign m      = m_q;
  assign result = res_q;

endmodule

// File: tb/tb_obc_bitslice_sequencer.sv
// Randomized self-checking bench for obc_bitslice_sequencer (default and OUT_SHIFT=4 instances).
module tb_obc_bitslice_sequencer;

  logic                clk = 1'b0;
  logic                rst_n, in_valid, out_ready;
  logic [255:0]        samples;
  logic [31:0]         rom_data;
  logic                in_ready, m, out_valid;
  logic [15:0]         slice;
  logic signed [47:0]  result;
  logic                in_ready4, m4, out_valid4;
  logic [15:0]         slice4;
  logic signed [47:0]  result4;
  int                  mode;
  logic [31:0]         rom_c;
  int                  tests_run = 0;
  int                  fails = 0;

  always #5 clk = ~clk;

  obc_bitslice_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .samples(samples), .slice(slice), .m(m), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result));

  obc_bitslice_sequencer #(.OUT_SHIFT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .samples(samples), .slice(slice4), .m(m4), .rom_data(rom_data),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4));

  // ROM stub: 0 = constant, 1 = one-hot position + 1, 2 = hash of slice/m.
  function automatic logic [31:0] rom_fn(input int md, input logic [31:0] c,
                                         input logic [15:0] s, input logic mm);
    int idx;
    idx = 0;
    case (md)
      0: return c;
      1: begin
        for (int i = 0; i < 16; i++) if (s[i]) idx = i + 1;
        return 32'(idx);
      end
      default: return {s, s ^ c[15:0]} ^ (mm ? {1'b1, c[30:0]} : 32'h0);
    endcase
  endfunction

  always_comb rom_data = rom_fn(mode, rom_c, slice, m);

  function automatic logic [15:0] slice_of(input logic [255:0] smp, input int b);
    logic [15:0] s;
    for (int k = 0; k < 16; k++) s[k] = smp[k*16 + b];
    return s;
  endfunction

  function automatic logic signed [47:0] model(input logic [255:0] smp, input int md,
                                               input logic [31:0] c, input int sh);
    longint acc;
    longint r;
    acc = 0;
    for (int b = 0; b < 16; b++) begin
      r = longint'($signed(rom_fn(md, c, slice_of(smp, b), b == 15)));
      acc = acc + r * (longint'(1) << b);
    end
`ifdef OBC_ROUND_EN
    if (sh > 0) acc = acc + (longint'(1) << (sh - 1));
`endif
    return 48'(acc >>> sh);
  endfunction

  task automatic run_frame(input logic [255:0] smp, input int md, input logic [31:0] c,
                           input logic signed [47:0] exp0, input logic signed [47:0] exp4,
                           input int hold, input bit noisy, input string tag);
    logic [15:0] es;
    mode = md; rom_c = c; samples = smp;
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL %s in_ready_idle got %b exp 1", tag, in_ready); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) samples[i*32 +: 32] = $urandom;
    for (int b = 0; b < 16; b++) begin
      es = slice_of(smp, b);
      tests_run++;
      if (slice !== es) begin fails++; $display("FAIL %s slice b=%0d got %h exp %h", tag, b, slice, es); end
      tests_run++;
      if (m !== (b == 15)) begin fails++; $display("FAIL %s m b=%0d got %b exp %b", tag, b, m, b == 15); end
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL %s busy b=%0d out_valid %b in_ready %b exp 0 0", tag, b, out_valid, in_ready);
      end
      if (noisy) begin in_valid = 1'($urandom); out_ready = 1'($urandom); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL %s done_latency out_valid %b in_ready %b exp 1 0", tag, out_valid, in_ready);
    end
    for (int i = 0; i <= hold; i++) begin
      tests_run++;
      if (result !== exp0) begin fails++; $display("FAIL %s result got %0d exp %0d", tag, result, exp0); end
      tests_run++;
      if (result4 !== exp4) begin fails++; $display("FAIL %s result_sh4 got %0d exp %0d", tag, result4, exp4); end
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || slice !== 16'h0 || m !== 1'b0) begin
        fails++; $display("FAIL %s hold%0d out_valid %b in_ready %b slice %h m %b exp 1 0 0 0", tag, i, out_valid, in_ready, slice, m);
      end
      if (i < hold) begin
        in_valid = (i == 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL %s handshake out_valid %b in_ready %b exp 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; samples = '0; mode = 0; rom_c = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || slice !== 16'h0 || m !== 1'b0 || result !== 48'sd0 || result4 !== 48'sd0) begin
      fails++; $display("FAIL reset in_ready %b out_valid %b slice %h m %b result %0d exp 1 0 0 0 0", in_ready, out_valid, slice, m, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
`ifdef OBC_ROUND_EN
    run_frame('0, 0, 32'd1, 48'sd65535, 48'sd4096, 0, 1'b0, "rom_one");
`else
    run_frame('0, 0, 32'd1, 48'sd65535, 48'sd4095, 0, 1'b0, "rom_one");
`endif
  endtask

  task automatic test_neg();
    run_frame('0, 0, 32'hFFFF_FFFF, 48'hFFFF_FFFF_0001, model('0, 0, 32'hFFFF_FFFF, 4), 0, 1'b0, "rom_neg");
  endtask

  task automatic test_onehot();
    logic [255:0] smp;
    for (int k = 0; k < 16; k++) smp[k*16 +: 16] = 16'h0001 << k;
    run_frame(smp, 1, 32'd0, 48'sd983041, model(smp, 1, 32'd0, 4), 0, 1'b0, "onehot");
  endtask

  task automatic test_hold();
    logic [255:0] smp;
    logic [31:0]  c;
    for (int i = 0; i < 8; i++) smp[i*32 +: 32] = $urandom;
    c = $urandom;
    run_frame(smp, 2, c, model(smp, 2, c, 0), model(smp, 2, c, 4), 5, 1'b0, "hold");
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || slice !== 16'h0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL hold_no_capture in_ready %b slice %h out_valid %b exp 1 0 0", in_ready, slice, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0; rom_c = 32'd1; samples = '1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    tests_run++;
    if (slice !== 16'hFFFF) begin fails++; $display("FAIL mid_slice7 got %h exp ffff", slice); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || slice !== 16'h0 || m !== 1'b0 || result !== 48'sd0) begin
      fails++; $display("FAIL mid_reset in_ready %b out_valid %b slice %h m %b result %0d exp 1 0 0 0 0", in_ready, out_valid, slice, m, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef OBC_ROUND_EN
    run_frame('0, 0, 32'd1, 48'sd65535, 48'sd4096, 0, 1'b0, "post_reset");
`else
    run_frame('0, 0, 32'd1, 48'sd65535, 48'sd4095, 0, 1'b0, "post_reset");
`endif
  endtask

  task automatic test_back_to_back();
    logic [255:0] smp;
    logic [31:0]  c;
    int           md;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) smp[i*32 +: 32] = $urandom;
      c  = $urandom;
      md = (n % 3 == 0) ? 0 : 2;
      run_frame(smp, md, c, model(smp, md, c, 0), model(smp, md, c, 4),
                int'($urandom_range(0, 3)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_neg();
    test_onehot();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
